// File: rtl/uart_rx_bcd.sv
// UART 8N1 receiver feeding a two-digit BCD shift register from ASCII '0'..'9' bytes.
// Non-digit bytes and bad stop bits are flagged without disturbing the held digits.
module uart_rx_bcd #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       digit_err,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic       bcd_valid,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      bit_cnt, bit_nx;
  logic [7:0]      shift, shift_nx;
  logic [1:0]      sync;
  logic            rxs;
  logic            stop_ok, stop_bad;
  logic            is_digit;

  // Synchronizer presets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx_in};
  end
  assign rxs = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_nx;
      shift   <= shift_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    bit_nx   = bit_cnt;
    shift_nx = shift;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        bit_nx = '0;
        if (!rxs) state_nx = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_nx   = '0;
          state_nx = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_nx   = '0;
          shift_nx = {rxs, shift[7:1]};
          bit_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is still caught in IDLE.
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_nx = '0;
          if (rxs) begin
            stop_ok  = 1'b1;
            state_nx = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nx = '0;
        if (rxs) state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign is_digit = (shift[7:4] == 4'h3) && (shift[3:0] <= 4'd9);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      digit_err <= 1'b0;
      bcd_valid <= 1'b0;
      bcd0      <= '0;
      bcd1      <= '0;
    end else begin
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      bcd_valid <= stop_ok && is_digit;
      digit_err <= stop_ok && !is_digit;
      if (stop_ok) begin
        rx_data <= shift;
        if (is_digit) begin
          bcd1 <= bcd0;
          bcd0 <= shift[3:0];
        end
      end
    end
  end

endmodule
